instr_fetch_sequencer: RTL and testbench

- Requester side of the instruction-memory interface: owns the program counter and drives the word index into the combinational instruction memory.
- Captures the returned word together with its PC into a small FIFO and hands it to decode with a valid/ready handshake.
- Reacts to the memory's end-of-program flag (isdone) by halting fetch.
- Accepts branch/jump redirects from execute.

---
 rtl/instr_fetch_sequencer_pkg.sv | 18 +
 rtl/instr_fetch_sequencer_fifo.sv | 66 ++++++
 rtl/instr_fetch_sequencer.sv | 98 +++++++++
 tb/tb_instr_fetch_sequencer.sv | 230 +++++++++++++++++++++++
 4 files changed

// File: rtl/instr_fetch_sequencer_pkg.sv
// Shared fetch definitions: FSM encodings, fetch-queue entry layout and the
// default reset PC / memory depth also used by the instruction memory.
package instr_fetch_sequencer_pkg;

    typedef enum logic [0:0] {
        FETCH_RUN  = 1'b0,
        FETCH_HALT = 1'b1
    } fetch_state_t;

    typedef struct packed {
        logic [31:0] pc;
        logic [31:0] instr;
    } fetch_entry_t;

    localparam logic [31:0] DEFAULT_RESET_PC  = 32'd0;
    localparam int unsigned DEFAULT_MEM_WORDS = 1024;

endpackage

// File: rtl/instr_fetch_sequencer_fifo.sv
// DEPTH-entry {pc, instr} queue with registered head; push to head visible next cycle.
// Push while full is accepted only alongside a pop; flush empties it and beats push/pop.
module fetch_fifo
    import instr_fetch_sequencer_pkg::*;
#(
    parameter int unsigned DEPTH = 2
) (
    input  logic                       clk,
    input  logic                       rst,
    input  logic                       push,
    input  logic                       pop,
    input  logic                       flush,
    input  fetch_entry_t               wr_dat,
    output fetch_entry_t               rd_dat,
    output logic                       full,
    output logic                       empty,
    output logic [$clog2(DEPTH):0]     count
);

    localparam int unsigned AW = $clog2(DEPTH);
    localparam int unsigned CW = AW + 1;
    localparam logic [CW-1:0] FULL_CNT = CW'(DEPTH);

    fetch_entry_t      mem [DEPTH];
    logic [AW-1:0]     wr_ptr;
    logic [AW-1:0]     rd_ptr;
    logic              do_push;
    logic              do_pop;

    assign full   = (count == FULL_CNT);
    assign empty  = (count == '0);
    assign rd_dat = mem[rd_ptr];

    // A full queue takes a push only when the head leaves in the same cycle.
    assign do_push = push & (~full | pop);
    assign do_pop  = pop & ~empty;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            count  <= '0;
            for (int unsigned i = 0; i < DEPTH; i++) begin
                mem[i] <= '0;
            end
        end else if (flush) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            count  <= '0;
        end else begin
            if (do_push) begin
                mem[wr_ptr] <= wr_dat;
                wr_ptr      <= wr_ptr + 1'b1;
            end
            if (do_pop) begin
                rd_ptr <= rd_ptr + 1'b1;
            end
            case ({do_push, do_pop})
                2'b10:   count <= count + 1'b1;
                2'b01:   count <= count - 1'b1;
                default: count <= count;
            endcase
        end
    end

endmodule

// File: rtl/instr_fetch_sequencer.sv
// Owns the fetch PC, queues {pc, instr} toward decode; word fetched in cycle N is at out_* in N+1.
// Fetch stalls while the queue is full and not popping; halts on end-of-program or out-of-range PC.
module instr_fetch_sequencer
    import instr_fetch_sequencer_pkg::*;
#(
    parameter logic [31:0] RESET_PC  = DEFAULT_RESET_PC,
    parameter int unsigned MEM_WORDS = DEFAULT_MEM_WORDS,
    parameter int unsigned DEPTH     = 2
) (
    input  logic        clk,
    input  logic        rst,
    output logic [31:0] imem_pc,
    input  logic [31:0] imem_instr,
    input  logic        imem_isdone,
    input  logic        redirect_valid,
    input  logic [31:0] redirect_pc,
    output logic        out_valid,
    output logic [31:0] out_instr,
    output logic [31:0] out_pc,
    input  logic        out_ready,
    output logic        halted
);

    localparam logic [31:0] MEM_LIMIT = 32'(MEM_WORDS);

    fetch_state_t           state;
    fetch_state_t           state_nxt;
    logic [31:0]            fetch_pc;
    logic [31:0]            fetch_pc_nxt;
    logic                   push;
    logic                   flush;
    logic                   pop;
    logic                   space;
    logic                   out_of_range;
    logic                   fifo_full;
    logic                   fifo_empty;
    logic [$clog2(DEPTH):0] fifo_count;
    fetch_entry_t           wr_entry;
    fetch_entry_t           head;

    assign imem_pc      = fetch_pc;
    assign out_valid    = ~fifo_empty;
    assign out_instr    = head.instr;
    assign out_pc       = head.pc;
    assign pop          = out_valid & out_ready;
    assign space        = ~fifo_full | pop;
    assign out_of_range = (fetch_pc >= MEM_LIMIT);
    assign halted       = (state == FETCH_HALT) & (fifo_count == '0);

    assign wr_entry.pc    = fetch_pc;
    assign wr_entry.instr = imem_instr;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state    <= FETCH_RUN;
            fetch_pc <= RESET_PC;
        end else begin
            state    <= state_nxt;
            fetch_pc <= fetch_pc_nxt;
        end
    end

    // Redirect wins in any state; the queue flush also swallows a same-cycle pop.
    always_comb begin
        state_nxt    = state;
        fetch_pc_nxt = fetch_pc;
        push         = 1'b0;
        flush        = 1'b0;
        if (redirect_valid) begin
            flush        = 1'b1;
            fetch_pc_nxt = redirect_pc;
            state_nxt    = FETCH_RUN;
        end else if (state == FETCH_RUN) begin
            if (imem_isdone | out_of_range) begin
                state_nxt = FETCH_HALT;
            end else if (space) begin
                push         = 1'b1;
                fetch_pc_nxt = fetch_pc + 32'd1;
            end
        end
    end

    fetch_fifo #(
        .DEPTH (DEPTH)
    ) u_fifo (
        .clk    (clk),
        .rst    (rst),
        .push   (push),
        .pop    (pop),
        .flush  (flush),
        .wr_dat (wr_entry),
        .rd_dat (head),
        .full   (fifo_full),
        .empty  (fifo_empty),
        .count  (fifo_count)
    );

endmodule

// File: tb/tb_instr_fetch_sequencer.sv
// Directed bench: main instance (1024-word memory) plus a 4-word instance for the range limit.
module tb_instr_fetch_sequencer;

    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic        rst4 = 1'b1;

    logic [31:0] imem_pc, imem_instr, redirect_pc, out_instr, out_pc;
    logic        imem_isdone, redirect_valid, out_valid, out_ready, halted;
    logic [31:0] prog_end;

    logic [31:0] imem_pc4, imem_instr4, redirect_pc4, out_instr4, out_pc4;
    logic        redirect_valid4, out_valid4, out_ready4, halted4;
    logic        imem_isdone4;

    int errors = 0;
    int checks = 0;

    always #5 clk = ~clk;

    function automatic logic [31:0] instr_at(input logic [31:0] pc);
        case (pc)
            32'd0:   return 32'h0000_0013;
            32'd1:   return 32'h0010_0093;
            32'd2:   return 32'h0020_0113;
            32'd3:   return 32'h0030_0193;
            default: return {16'hA5A5, pc[15:0]};
        endcase
    endfunction

    assign imem_instr   = instr_at(imem_pc);
    assign imem_isdone  = (imem_pc >= prog_end);
    assign imem_instr4  = instr_at(imem_pc4);
    assign imem_isdone4 = 1'b0;

    instr_fetch_sequencer u_dut (
        .clk            (clk),
        .rst            (rst),
        .imem_pc        (imem_pc),
        .imem_instr     (imem_instr),
        .imem_isdone    (imem_isdone),
        .redirect_valid (redirect_valid),
        .redirect_pc    (redirect_pc),
        .out_valid      (out_valid),
        .out_instr      (out_instr),
        .out_pc         (out_pc),
        .out_ready      (out_ready),
        .halted         (halted)
    );

    instr_fetch_sequencer #(.MEM_WORDS(4)) u_dut4 (
        .clk            (clk),
        .rst            (rst4),
        .imem_pc        (imem_pc4),
        .imem_instr     (imem_instr4),
        .imem_isdone    (imem_isdone4),
        .redirect_valid (redirect_valid4),
        .redirect_pc    (redirect_pc4),
        .out_valid      (out_valid4),
        .out_instr      (out_instr4),
        .out_pc         (out_pc4),
        .out_ready      (out_ready4),
        .halted         (halted4)
    );

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s: observed %h expected %h", tag, obs, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic pulse_reset();
        rst = 1'b1;
        #1;
        @(negedge clk);
        rst = 1'b0;
    endtask

    initial begin
        out_ready       = 1'b1;
        redirect_valid  = 1'b0;
        redirect_pc     = 32'd0;
        prog_end        = 32'd4;
        out_ready4      = 1'b1;
        redirect_valid4 = 1'b0;
        redirect_pc4    = 32'd0;

        // Reset state
        #2;
        chk("rst out_valid", {31'd0, out_valid}, 32'd0);
        chk("rst out_instr", out_instr, 32'd0);
        chk("rst out_pc", out_pc, 32'd0);
        chk("rst halted", {31'd0, halted}, 32'd0);
        chk("rst imem_pc", imem_pc, 32'd0);
        @(negedge clk);
        rst = 1'b0;

        // Free run to isdone at pc 4
        tick();
        chk("run v0", {31'd0, out_valid}, 32'd1);
        chk("run pc0", out_pc, 32'd0);
        chk("run in0", out_instr, 32'h0000_0013);
        chk("run imem1", imem_pc, 32'd1);
        tick();
        chk("run pc1", out_pc, 32'd1);
        chk("run in1", out_instr, 32'h0010_0093);
        tick();
        chk("run pc2", out_pc, 32'd2);
        chk("run in2", out_instr, 32'h0020_0113);
        tick();
        chk("run pc3", out_pc, 32'd3);
        chk("run in3", out_instr, 32'h0030_0193);
        tick();
        chk("done halted", {31'd0, halted}, 32'd1);
        chk("done valid", {31'd0, out_valid}, 32'd0);
        chk("done imem", imem_pc, 32'd4);
        tick();
        chk("done imem hold", imem_pc, 32'd4);
        chk("done halted hold", {31'd0, halted}, 32'd1);

        // Backpressure: two pushes fill the queue, fetch freezes at 2
        out_ready = 1'b0;
        prog_end  = 32'd64;
        pulse_reset();
        tick();
        tick();
        for (int i = 0; i < 3; i++) begin
            tick();
            chk("bp valid", {31'd0, out_valid}, 32'd1);
            chk("bp head", out_pc, 32'd0);
            chk("bp imem", imem_pc, 32'd2);
            chk("bp count", 32'(u_dut.u_fifo.count), 32'd2);
        end

        // Pop+push while full: count holds at 2, head advances by one
        out_ready = 1'b1;
        for (int i = 1; i <= 5; i++) begin
            tick();
            chk("pp head", out_pc, 32'(i));
            chk("pp count", 32'(u_dut.u_fifo.count), 32'd2);
            chk("pp imem", imem_pc, 32'(i + 2));
        end

        // Redirect with queue holding 5,6 and a pop in the same cycle
        redirect_valid = 1'b1;
        redirect_pc    = 32'h20;
        tick();
        redirect_valid = 1'b0;
        chk("rd count", 32'(u_dut.u_fifo.count), 32'd0);
        chk("rd valid", {31'd0, out_valid}, 32'd0);
        chk("rd imem", imem_pc, 32'h20);
        tick();
        chk("rd head", out_pc, 32'h20);
        chk("rd instr", out_instr, 32'hA5A5_0020);
        tick();
        chk("rd head2", out_pc, 32'h21);

        // End program at 0x22, then redirect out of HALT to pc 1
        prog_end = 32'h22;
        tick();
        chk("h halted", {31'd0, halted}, 32'd1);
        chk("h imem", imem_pc, 32'h22);
        redirect_valid = 1'b1;
        redirect_pc    = 32'd1;
        prog_end       = 32'd64;
        tick();
        redirect_valid = 1'b0;
        chk("hr halted", {31'd0, halted}, 32'd0);
        chk("hr valid", {31'd0, out_valid}, 32'd0);
        chk("hr imem", imem_pc, 32'd1);
        tick();
        chk("hr head", out_pc, 32'd1);
        chk("hr instr", out_instr, 32'h0010_0093);
        tick();
        chk("hr head2", out_pc, 32'd2);

        // Async reset between edges
        #2;
        rst = 1'b1;
        #1;
        chk("ar valid", {31'd0, out_valid}, 32'd0);
        chk("ar imem", imem_pc, 32'd0);
        chk("ar pc", out_pc, 32'd0);
        chk("ar instr", out_instr, 32'd0);
        @(negedge clk);
        rst = 1'b0;

        // isdone with a full queue: HALT taken, pc 2 never queued
        out_ready = 1'b0;
        prog_end  = 32'd2;
        tick();
        tick();
        tick();
        chk("df imem", imem_pc, 32'd2);
        chk("df halted", {31'd0, halted}, 32'd0);
        chk("df head", out_pc, 32'd0);
        prog_end  = 32'd64;
        out_ready = 1'b1;
        tick();
        chk("df head1", out_pc, 32'd1);
        chk("df imem hold", imem_pc, 32'd2);
        tick();
        chk("df halted2", {31'd0, halted}, 32'd1);
        chk("df valid2", {31'd0, out_valid}, 32'd0);

        // Range limit on the 4-word instance
        @(negedge clk);
        rst4 = 1'b0;
        for (int i = 0; i < 4; i++) begin
            tick();
            chk("rl head", out_pc4, 32'(i));
            chk("rl valid", {31'd0, out_valid4}, 32'd1);
        end
        chk("rl instr3", out_instr4, 32'h0030_0193);
        tick();
        chk("rl halted", {31'd0, halted4}, 32'd1);
        chk("rl imem", imem_pc4, 32'd4);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
